doc_send_ctrl: RTL
==================

Name: doc_send_ctrl

Overview:
- Sequencer that streams the visible document grid (ROWS x COLS character cells) out as bytes on a valid/ready byte interface to the UART transmitter.
- Owns the single read/write port of the document RAM and shares it with the text editor. Editor writes always win; the scan stalls while the editor holds the port.
- Sits between text_editor, document and the UART TX. It replaces the tied-off UART read/address/done nets at top level.

Parameters:
- ROWS, 15, visible text rows scanned (row index 0..ROWS-1)
- COLS, 20, visible text columns scanned (col index 0..COLS-1)
- ROW_W, 4, row field width of the document address
- COL_W, 5, column field width of the document address

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- start  in  1  one-cycle pulse; begins a document send
- abort  in  1  one-cycle pulse; cancels a send in progress
- ed_we  in  1  editor write request
- ed_addr  in  ROW_W+COL_W  editor write address
- ed_wdata  in  8  editor write data
- doc_a  out  ROW_W+COL_W  document port address
- doc_we  out  1  document port write enable
- doc_d  out  8  document port write data
- doc_spo  in  8  document port read data (asynchronous, same-cycle)
- tx_valid  out  1  byte available to UART TX
- tx_data  out  8  byte to transmit
- tx_ready  in  1  UART TX accepts the byte when tx_valid and tx_ready are both 1
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst==0 at posedge clk) puts the block in IDLE with row=0, col=0, tx_valid=0, tx_data=0, busy=0, done=0. Reset takes effect mid-send with no done pulse.
- Port mux (combinational):
  - If ed_we=1: doc_a=ed_addr, doc_we=1, doc_d=ed_wdata, in every state.
  - Otherwise: doc_a={row,col}, doc_we=0, doc_d=0.
- FSM states: IDLE, FETCH, SEND, EOL_CR, EOL_LF, DONE.
- IDLE: start=1 moves to FETCH and clears row and col. start is ignored in every other state.
- FETCH:
  - If ed_we=1, stay in FETCH (stall).
  - Otherwise latch tx_data = (doc_spo < 8'h20) ? 8'h20 : doc_spo, set tx_valid=1 and go to SEND.
- SEND:
  - tx_valid and tx_data are held stable until tx_ready=1.
  - On the handshake: tx_valid=0, then advance.
  - If col != COLS-1: col+1, go to FETCH.
  - If col == COLS-1: col=0, go to end-of-row handling (see Optional Feature).
  - End-of-row handling increments row, or goes to DONE when row == ROWS-1.
- DONE: done=1 for exactly one cycle, then IDLE, busy=0.
- abort=1 in any non-IDLE state moves to IDLE next cycle with tx_valid=0 and no done pulse. abort takes priority over tx_ready in the same cycle.
- Editor writes during SEND do not disturb the latched byte (per-byte snapshot).
- Latency: with no stalls, start to first tx_valid=1 is 2 cycles. Total bytes sent: ROWS*COLS = 300.
- Address and index widths:
  - Address = {row[ROW_W-1:0], col[COL_W-1:0]}.
  - Cells with col >= COLS or row >= ROWS are never read.
  - Counters never wrap past ROWS-1 / COLS-1.

Optional Feature:
- DOC_SEND_CRLF_EN defined: after the last column of each row, emit 8'h0D (EOL_CR), then 8'h0A (EOL_LF), each with its own valid/ready handshake. Then go to FETCH with row+1, or to DONE after the last row. Total 330 bytes.
- Not defined: EOL_CR and EOL_LF are unreachable. End of row goes directly to FETCH with row+1, or to DONE. Total 300 bytes.

Decomposition:
- Shared package doc_pkg holds:
  - ROW_W, COL_W, ROWS, COLS
  - the state enum
  - ASCII constants CHR_SPACE=8'h20, CHR_CR=8'h0D, CHR_LF=8'h0A
- Single module; the port mux stays inline. No sub-module is warranted.

Test Plan:
- Reset and basic send:
  - Stimulus: hold rst=0 for 3 cycles, then release. Preload doc[{0,0}]=8'h41, doc[{0,1}]=8'h42. Keep tx_ready=1 and pulse start.
  - Required response: tx_valid first high 2 cycles after start; first two bytes are 8'h41, 8'h42; all 300 bytes are sent; done pulses once; busy=0 after.
- Backpressure:
  - Stimulus: tx_ready low for 10 cycles on byte 5.
  - Required response: tx_data stays constant, tx_valid stays 1, col does not advance; the sequence continues unchanged after ready rises.
- Editor priority:
  - Stimulus: assert ed_we with ed_addr=9'h023, ed_wdata=8'h5A for 4 cycles while in FETCH.
  - Required response: doc_we=1 and doc_a=9'h023 during those cycles; the scan stalls, then resumes. The cell at {1,3} is read as 8'h5A if scanned later.
- Boundary and control:
  - Stimulus: cell value 8'h00 / 8'h1F.
  - Required response: sent as 8'h20.
  - Stimulus: start pulse while busy.
  - Required response: ignored, byte count stays 300.
  - Stimulus: abort at byte 100.
  - Required response: tx_valid=0 next cycle, no done, IDLE.
- Reset mid-send:
  - Stimulus: rst=0 during SEND.
  - Required response: next edge gives tx_valid=0, busy=0, done=0. A new start restarts at address 9'h000.
- CRLF build:
  - Stimulus: DOC_SEND_CRLF_EN defined.
  - Required response: bytes 21 and 22 are 8'h0D and 8'h0A; total 330 bytes before done.

Source files
------------

// File: rtl/doc_pkg.sv
// Shared constants for the document send path: grid geometry, FSM encodings, ASCII codes.
package doc_pkg;

  localparam int unsigned ROWS   = 15;
  localparam int unsigned COLS   = 20;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 5;
  localparam int unsigned ADDR_W = ROW_W + COL_W;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_SEND   = 3'd2;
  localparam state_t ST_EOL_CR = 3'd3;
  localparam state_t ST_EOL_LF = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  // Control codes would garble the terminal, so they go out as spaces.
  function automatic logic [7:0] printable(input logic [7:0] c);
    return (c < CHR_SPACE) ? CHR_SPACE : c;
  endfunction

endpackage

// File: rtl/doc_send_ctrl.sv
// Streams the visible document grid to the UART TX byte interface, sharing the RAM port with the editor.
// Define DOC_SEND_CRLF_EN to append CR/LF after every row.
module doc_send_ctrl
  import doc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ed_we,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic [7:0]        ed_wdata,
  output logic [ADDR_W-1:0] doc_a,
  output logic              doc_we,
  output logic [7:0]        doc_d,
  input  logic [7:0]        doc_spo,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Editor always owns the port when it writes; otherwise the scan address reads.
  assign doc_a  = ed_we ? ed_addr : {row_q, col_q};
  assign doc_we = ed_we;
  assign doc_d  = ed_we ? ed_wdata : 8'h00;

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_FETCH: begin
        if (!ed_we) begin
          tx_data_d  = printable(doc_spo);
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (col_q != COL_LAST) begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_FETCH;
          end else begin
            col_d = '0;
`ifdef DOC_SEND_CRLF_EN
            tx_valid_d = 1'b1;
            tx_data_d  = CHR_CR;
            state_d    = ST_EOL_CR;
`else
            if (row_q == ROW_LAST) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = ST_FETCH;
            end
`endif
          end
        end
      end
      ST_EOL_CR: begin
        if (tx_ready) begin
          tx_data_d = CHR_LF;
          state_d   = ST_EOL_LF;
        end
      end
      ST_EOL_LF: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any handshake in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

endmodule
